// File: rtl/isp_gamma_lut.sv
// Gamma stage: each active pixel goes through a programmable curve with linear interpolation.
// Fixed 3-cycle latency, href/vsync delayed to match, no backpressure (one pixel per pclk).
module isp_gamma_lut #(
   parameter int BITS       = 8,
   parameter int WIDTH      = 1280,
   parameter int HEIGHT     = 720,
   parameter int TABLE_BITS = 6
) (
   input  logic                  pclk,
   input  logic                  rst,
   input  logic                  in_href,
   input  logic                  in_vsync,
   input  logic [BITS-1:0]       in_data,
   output logic                  out_href,
   output logic                  out_vsync,
   output logic [BITS-1:0]       out_data,
   input  logic                  cfg_table_wen,
   input  logic                  cfg_table_ren,
   input  logic [TABLE_BITS-1:0] cfg_table_addr,
   input  logic [TABLE_BITS-1:0] cfg_table_wdata,
   output logic [TABLE_BITS-1:0] cfg_table_rdata
);

   localparam int S       = BITS - TABLE_BITS;
   localparam int FW      = (S > 0) ? S : 1;
   localparam int ENTRIES = 1 << TABLE_BITS;
   localparam int VW      = BITS + 1;
   localparam int DW      = BITS + 2;
   localparam int PW      = DW + FW + 1;
   localparam logic signed [PW-1:0] MAX_OUT = PW'((1 << BITS) - 1);

   // Frame geometry only matters to neighbouring stages.
   logic unused_params;
   assign unused_params = (WIDTH > 0) ^ (HEIGHT > 0);

   logic [TABLE_BITS-1:0] tbl [ENTRIES];

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < ENTRIES; k++) tbl[k] <= TABLE_BITS'(k);
         cfg_table_rdata <= '0;
      end else begin
         if (cfg_table_wen) tbl[cfg_table_addr] <= cfg_table_wdata;
         if (cfg_table_ren) cfg_table_rdata <= tbl[cfg_table_addr];
      end
   end

   logic [TABLE_BITS-1:0] idx, idx_nxt;
   logic [FW-1:0]         frac_n;
   logic [VW-1:0]         v0_n, v1_n;

   // The last segment interpolates towards full scale, one step above the largest code.
   always_comb begin
      idx     = in_data[BITS-1 -: TABLE_BITS];
      idx_nxt = idx + TABLE_BITS'(1);
      frac_n  = (S > 0) ? in_data[FW-1:0] : '0;
      v0_n    = VW'(tbl[idx]) << S;
      v1_n    = (&idx) ? (VW'(1) << BITS) : (VW'(tbl[idx_nxt]) << S);
   end

   logic          s1_href, s1_vsync;
   logic [VW-1:0] s1_v0, s1_v1;
   logic [FW-1:0] s1_frac;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         s1_href  <= 1'b0;
         s1_vsync <= 1'b0;
         s1_v0    <= '0;
         s1_v1    <= '0;
         s1_frac  <= '0;
      end else begin
         s1_href  <= in_href;
         s1_vsync <= in_vsync;
         s1_v0    <= v0_n;
         s1_v1    <= v1_n;
         s1_frac  <= frac_n;
      end
   end

   logic signed [DW-1:0] diff;
   logic signed [PW-1:0] prod_n;

   always_comb begin
      diff   = $signed({1'b0, s1_v1}) - $signed({1'b0, s1_v0});
      prod_n = PW'(diff) * PW'($signed({1'b0, s1_frac}));
   end

   logic                 s2_href, s2_vsync;
   logic [VW-1:0]        s2_v0;
   logic signed [PW-1:0] s2_prod;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         s2_href  <= 1'b0;
         s2_vsync <= 1'b0;
         s2_v0    <= '0;
         s2_prod  <= '0;
      end else begin
         s2_href  <= s1_href;
         s2_vsync <= s1_vsync;
         s2_v0    <= s1_v0;
         s2_prod  <= prod_n;
      end
   end

   logic signed [PW-1:0] sum;
   logic [BITS-1:0]      clamped;

   // Arithmetic shift rounds a falling segment towards -inf.
   always_comb begin
      sum = $signed(PW'(s2_v0)) + (s2_prod >>> S);
      if (sum < 0)
         clamped = '0;
      else if (sum > MAX_OUT)
         clamped = '1;
      else
         clamped = sum[BITS-1:0];
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         out_href  <= 1'b0;
         out_vsync <= 1'b0;
         out_data  <= '0;
      end else begin
         out_href  <= s2_href;
         out_vsync <= s2_vsync;
         out_data  <= s2_href ? clamped : '0;
      end
   end

endmodule

// File: tb/tb_isp_gamma_lut.sv
// Directed table-driven bench for isp_gamma_lut (BITS=8, TABLE_BITS=6).
module tb_isp_gamma_lut;

   logic       pclk = 1'b0;
   logic       rst;
   logic       in_href, in_vsync;
   logic [7:0] in_data;
   logic       out_href, out_vsync;
   logic [7:0] out_data;
   logic       cfg_table_wen, cfg_table_ren;
   logic [5:0] cfg_table_addr, cfg_table_wdata, cfg_table_rdata;

   int n_pass  = 0;
   int n_total = 0;

   always #5 pclk = ~pclk;

   isp_gamma_lut #(.BITS(8), .WIDTH(1280), .HEIGHT(720), .TABLE_BITS(6)) dut (
      .pclk            (pclk),
      .rst             (rst),
      .in_href         (in_href),
      .in_vsync        (in_vsync),
      .in_data         (in_data),
      .out_href        (out_href),
      .out_vsync       (out_vsync),
      .out_data        (out_data),
      .cfg_table_wen   (cfg_table_wen),
      .cfg_table_ren   (cfg_table_ren),
      .cfg_table_addr  (cfg_table_addr),
      .cfg_table_wdata (cfg_table_wdata),
      .cfg_table_rdata (cfg_table_rdata)
   );

   typedef struct {
      logic       href;
      logic       vsync;
      logic [7:0] data;
      logic       wen;
      logic [5:0] waddr;
      logic [5:0] wdata;
      logic [7:0] exp;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   function automatic vec_t px(input logic href, input logic vsync,
                               input logic [7:0] data, input logic [7:0] exp);
      vec_t v;
      v.href = href; v.vsync = vsync; v.data = data;
      v.wen = 1'b0; v.waddr = '0; v.wdata = '0;
      v.exp = href ? exp : 8'd0;
      return v;
   endfunction

   task automatic idle_inputs;
      in_href = 1'b0; in_vsync = 1'b0; in_data = '0;
      cfg_table_wen = 1'b0; cfg_table_ren = 1'b0;
      cfg_table_addr = '0; cfg_table_wdata = '0;
   endtask

   // Vector i is driven before edge i+1; its result is visible after edge i+3.
   task automatic run_stream(input string name);
      for (int i = 0; i < vq.size() + 2; i++) begin
         if (i < vq.size()) begin
            in_href = vq[i].href; in_vsync = vq[i].vsync; in_data = vq[i].data;
            cfg_table_wen = vq[i].wen; cfg_table_addr = vq[i].waddr;
            cfg_table_wdata = vq[i].wdata;
         end else begin
            idle_inputs();
         end
         tick();
         if (i >= 2) begin
            check({name, " data"},  out_data,  vq[i-2].exp);
            check({name, " href"},  out_href,  vq[i-2].href);
            check({name, " vsync"}, out_vsync, vq[i-2].vsync);
         end
      end
      idle_inputs();
      vq.delete();
   endtask

   task automatic cfg_write(input logic [5:0] addr, input logic [5:0] data);
      cfg_table_wen = 1'b1; cfg_table_addr = addr; cfg_table_wdata = data;
      tick();
      cfg_table_wen = 1'b0;
   endtask

   task automatic cfg_read(input string name, input logic [5:0] addr, input int exp);
      cfg_table_ren = 1'b1; cfg_table_addr = addr;
      tick();
      cfg_table_ren = 1'b0;
      check(name, cfg_table_rdata, exp);
   endtask

   initial begin
      vec_t v;
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      check("reset out_href", out_href, 0);
      check("reset out_vsync", out_vsync, 0);
      check("reset out_data", out_data, 0);
      check("reset rdata", cfg_table_rdata, 0);
      rst = 1'b0;
      tick();
      cfg_read("reset table[63]", 6'd63, 63);

      // Identity ramp
      for (int i = 0; i < 256; i++) vq.push_back(px(1'b1, 1'b0, 8'(i), 8'(i)));
      run_stream("ramp");

      // Two full lines framed by vsync; blanking carries junk data that must not leak
      for (int i = 0; i < 3; i++) vq.push_back(px(1'b0, 1'b1, 8'hAA, 8'd0));
      for (int i = 0; i < 4; i++) vq.push_back(px(1'b0, 1'b0, 8'h55, 8'd0));
      for (int ln = 0; ln < 2; ln++) begin
         for (int i = 0; i < 1280; i++)
            vq.push_back(px(1'b1, 1'b0, 8'(i + ln * 7), 8'(i + ln * 7)));
         for (int i = 0; i < 6; i++) vq.push_back(px(1'b0, 1'b0, 8'hC3, 8'd0));
      end
      for (int i = 0; i < 2; i++) vq.push_back(px(1'b0, 1'b1, 8'hFF, 8'd0));
      run_stream("timing");

      // Gamma curve points plus a falling segment (table[10]=20, table[11]=5)
      cfg_write(6'd1, 6'd9);
      cfg_write(6'd2, 6'd13);
      cfg_write(6'd32, 6'd46);
      cfg_write(6'd63, 6'd63);
      cfg_write(6'd10, 6'd20);
      cfg_write(6'd11, 6'd5);
      vq.push_back(px(1'b1, 1'b0, 8'd4,   8'd36));
      vq.push_back(px(1'b1, 1'b0, 8'd6,   8'd44));
      vq.push_back(px(1'b1, 1'b0, 8'd5,   8'd40));
      vq.push_back(px(1'b0, 1'b0, 8'd128, 8'd0));
      vq.push_back(px(1'b1, 1'b0, 8'd128, 8'd184));
      vq.push_back(px(1'b1, 1'b0, 8'd255, 8'd255));
      vq.push_back(px(1'b1, 1'b0, 8'd0,   8'd0));
      vq.push_back(px(1'b1, 1'b0, 8'd40,  8'd80));
      vq.push_back(px(1'b1, 1'b0, 8'd41,  8'd65));
      vq.push_back(px(1'b1, 1'b0, 8'd43,  8'd35));
      vq.push_back(px(1'b1, 1'b0, 8'd44,  8'd20));
      run_stream("gamma");

      // Live table write: the pixel sampled on the write edge still sees the old entry
      for (int i = 0; i < 3; i++) vq.push_back(px(1'b1, 1'b0, 8'd128, 8'd184));
      v = px(1'b1, 1'b0, 8'd128, 8'd184);
      v.wen = 1'b1; v.waddr = 6'd32; v.wdata = 6'd0;
      vq.push_back(v);
      for (int i = 0; i < 3; i++) vq.push_back(px(1'b1, 1'b0, 8'd128, 8'd0));
      run_stream("live write");

      // Config port read-back
      cfg_write(6'd5, 6'd19);
      cfg_read("read addr5", 6'd5, 19);
      cfg_table_wen = 1'b1; cfg_table_ren = 1'b1;
      cfg_table_addr = 6'd5; cfg_table_wdata = 6'd7;
      tick();
      idle_inputs();
      check("read during write", cfg_table_rdata, 19);
      tick();
      check("rdata hold", cfg_table_rdata, 19);
      cfg_read("read after write", 6'd5, 7);

      // Reset mid-line
      in_href = 1'b1; in_data = 8'd6;
      tick(); tick(); tick();
      check("pre-reset data", out_data, 44);
      rst = 1'b1;
      #1;
      check("async rst href", out_href, 0);
      check("async rst data", out_data, 0);
      check("async rst rdata", cfg_table_rdata, 0);
      tick(); tick();
      rst = 1'b0;
      idle_inputs();
      vq.push_back(px(1'b1, 1'b0, 8'd100, 8'd100));
      vq.push_back(px(1'b1, 1'b0, 8'd6,   8'd6));
      vq.push_back(px(1'b1, 1'b0, 8'd128, 8'd128));
      vq.push_back(px(1'b1, 1'b0, 8'd41,  8'd41));
      run_stream("post reset");
      cfg_read("post reset table[5]", 6'd5, 5);
      cfg_read("post reset table[32]", 6'd32, 32);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
